// File: rtl/pc_sequencer.sv
// Program-counter stage: holds PC, sticky overflow flag (V) and retired-instruction counter,
// and selects the next PC from PC+4, a PC-relative branch target or a pseudo-direct jump target.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch,
  input  logic                 b_invert,
  input  logic                 balv_s,
  input  logic                 jump,
  input  logic                 link,
  input  logic                 alu_zero,
  input  logic                 alu_ovf,
  input  logic                 v_update,
  input  logic [15:0]          imm16,
  input  logic [25:0]          jtarget,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic [31:0]          link_addr,
  output logic                 v_flag,
  output logic                 taken,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] br_offset;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;
  logic [XLEN-1:0] next_pc;
  logic            cond;
  logic            br_taken;

  // Target generation and redirect decision; jump outranks a taken branch.
  always_comb begin
    pc_plus4  = pc + XLEN'(4);
    br_offset = {{14{imm16[15]}}, imm16, 2'b00};
    br_target = pc_plus4 + br_offset;
    j_target  = {pc_plus4[31:28], jtarget, 2'b00};
    cond      = balv_s ? v_flag : (b_invert ? ~alu_zero : alu_zero);
    br_taken  = branch & cond;
    taken     = jump | br_taken;
    link_addr = link ? pc_plus4 : '0;
    next_pc   = pc_plus4;
    if (br_taken) next_pc = br_target;
    if (jump)     next_pc = j_target;
  end

  // balv samples v_flag before this edge updates it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      v_flag      <= 1'b0;
      instr_count <= '0;
    end else if (!stall) begin
      pc          <= next_pc;
      instr_count <= instr_count + CNT_WIDTH'(1);
      if (v_update) v_flag <= alu_ovf;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes model predictions, a negedge monitor
// pops and compares against the DUT.
module tb_pc_sequencer;

  localparam int unsigned CNT_WIDTH = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 stall, branch, b_invert, balv_s, jump, link;
  logic                 alu_zero, alu_ovf, v_update;
  logic [15:0]          imm16;
  logic [25:0]          jtarget;
  logic [31:0]          pc, pc_plus4, link_addr;
  logic                 v_flag, taken;
  logic [CNT_WIDTH-1:0] instr_count;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .b_invert(b_invert),
    .balv_s(balv_s), .jump(jump), .link(link), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .v_update(v_update), .imm16(imm16), .jtarget(jtarget), .pc(pc), .pc_plus4(pc_plus4),
    .link_addr(link_addr), .v_flag(v_flag), .taken(taken), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic stall, branch, b_invert, balv_s, jump, link, alu_zero, alu_ovf, v_update;
    logic [15:0] imm;
    logic [25:0] jt;
  } stim_t;

  typedef struct {
    logic [31:0] pc, pc4, link_addr, cnt;
    logic        v, taken;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Architectural model state
  logic [31:0] m_pc  = 32'h0;
  logic [31:0] m_cnt = 32'h0;
  logic        m_v   = 1'b0;

  function automatic stim_t nop();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic model_cond(stim_t s);
    if (s.balv_s) return m_v;
    return s.b_invert ? !s.alu_zero : s.alu_zero;
  endfunction

  function automatic logic [31:0] model_next(stim_t s);
    logic [31:0] seq;
    int          off;
    seq = m_pc + 32'd4;
    off = 4 * int'($signed(s.imm));
    if (s.jump) return (seq & 32'hF000_0000) | (32'(s.jt) * 32'd4);
    if (s.branch && model_cond(s)) return seq + 32'(off);
    return seq;
  endfunction

  function automatic exp_t predict(stim_t s, string tag);
    exp_t e;
    e.pc        = m_pc;
    e.pc4       = m_pc + 32'd4;
    e.link_addr = s.link ? e.pc4 : 32'h0;
    e.cnt       = m_cnt;
    e.v         = m_v;
    e.taken     = s.jump || (s.branch && model_cond(s));
    e.tag       = tag;
    return e;
  endfunction

  task automatic drive(stim_t s);
    stall = s.stall; branch = s.branch; b_invert = s.b_invert; balv_s = s.balv_s;
    jump = s.jump; link = s.link; alu_zero = s.alu_zero; alu_ovf = s.alu_ovf;
    v_update = s.v_update; imm16 = s.imm; jtarget = s.jt;
  endtask

  // Called just after a rising edge; leaves just after the next rising edge.
  task automatic apply(stim_t s, string tag);
    logic [31:0] nxt;
    drive(s);
    #1;
    sb.push_back(predict(s, tag));
    nxt = model_next(s);
    if (!s.stall) begin
      m_pc  = nxt;
      m_cnt = m_cnt + 32'd1;
      if (s.v_update) m_v = s.alu_ovf;
    end
    @(posedge clk);
    #1;
  endtask

  // Reset asserted mid-cycle; the monitor sees its effect before any clock edge.
  task automatic do_reset(string tag);
    drive(nop());
    reset = 1'b1;
    #1;
    m_pc = 32'h0; m_v = 1'b0; m_cnt = 32'h0;
    sb.push_back(predict(nop(), tag));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk(string tag, string f, logic [31:0] act, logic [31:0] expv);
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h (t=%0t)", tag, f, act, expv, $time);
    end
  endtask

  initial begin : monitor
    forever begin
      exp_t e;
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_vec++;
        chk(e.tag, "pc",          pc,                e.pc);
        chk(e.tag, "pc_plus4",    pc_plus4,          e.pc4);
        chk(e.tag, "link_addr",   link_addr,         e.link_addr);
        chk(e.tag, "instr_count", 32'(instr_count),  e.cnt);
        chk(e.tag, "v_flag",      32'(v_flag),       32'(e.v));
        chk(e.tag, "taken",       32'(taken),        32'(e.taken));
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    drive(nop());
    @(posedge clk);
    #1;
    do_reset("init_reset");

    // Walk to 0x40, then reset asynchronously
    for (int i = 0; i < 16; i++) apply(nop(), "seq_to_40");
    apply(nop(), "at_40");
    do_reset("async_reset");

    // Branch backward from 0 to 0xFFFF_FFF8, then sequential wrap
    s = nop(); s.branch = 1; s.alu_zero = 1; s.imm = 16'hFFFD;
    apply(s, "br_to_fff8");
    for (int i = 0; i < 4; i++) apply(nop(), "wrap");

    // beq backward / bneal not taken at 0x100
    do_reset("rst_beq");
    s = nop(); s.branch = 1; s.alu_zero = 1; s.imm = 16'h003F;
    apply(s, "br_to_100");
    s = nop(); s.branch = 1; s.alu_zero = 1; s.imm = 16'hFFFE;
    apply(s, "beq_back");
    apply(nop(), "seq_to_100");
    s = nop(); s.branch = 1; s.b_invert = 1; s.alu_zero = 1; s.link = 1; s.imm = 16'hFFFE;
    apply(s, "bneal_nt");
    s = nop(); s.branch = 1; s.b_invert = 1; s.alu_zero = 0; s.link = 1; s.imm = 16'h0010;
    apply(s, "bneal_t");

    // balv with flag set, with flag cleared, and with illegal simultaneous update
    do_reset("rst_balv");
    s = nop(); s.branch = 1; s.alu_zero = 1; s.imm = 16'h0007;
    apply(s, "br_to_20");
    s = nop(); s.v_update = 1; s.alu_ovf = 1;
    apply(s, "add_ovf");
    s = nop(); s.branch = 1; s.balv_s = 1; s.imm = 16'h0004;
    apply(s, "balv_t");
    s = nop(); s.branch = 1; s.balv_s = 1; s.imm = 16'h0004; s.v_update = 1; s.alu_ovf = 0;
    apply(s, "balv_old_v");
    s = nop(); s.branch = 1; s.balv_s = 1; s.imm = 16'h0004;
    apply(s, "balv_nt");

    // Climb to 0x1000_0000 in max forward branches, then jump-vs-branch priority
    do_reset("rst_jump");
    s = nop(); s.branch = 1; s.alu_zero = 1; s.imm = 16'h7FFF;
    for (int i = 0; i < 2048; i++) apply(s, "climb");
    s = nop(); s.jump = 1; s.branch = 1; s.alu_zero = 1; s.jt = 26'h10;
    apply(s, "jump_prio");

    // Stall holds state while taken stays asserted
    s = nop(); s.v_update = 1; s.alu_ovf = 1;
    apply(s, "set_v");
    s = nop(); s.stall = 1; s.jump = 1; s.jt = 26'h123; s.v_update = 1; s.alu_ovf = 0;
    for (int i = 0; i < 3; i++) apply(s, "stall");
    s.stall = 0;
    apply(s, "unstall_jump");
    apply(nop(), "post_stall");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset("rnd_reset");
      s.stall    = ($urandom_range(0, 3) == 0);
      s.branch   = ($urandom_range(0, 2) == 0);
      s.b_invert = 1'($urandom);
      s.balv_s   = ($urandom_range(0, 3) == 0);
      s.jump     = ($urandom_range(0, 7) == 0);
      s.link     = 1'($urandom);
      s.alu_zero = 1'($urandom);
      s.alu_ovf  = 1'($urandom);
      s.v_update = ($urandom_range(0, 2) == 0);
      s.imm      = 16'($urandom);
      s.jt       = 26'($urandom);
      apply(s, "random");
    end

    drive(nop());
    @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left in scoreboard, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
